ex_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, beside the ALU. It receives the same forwarded rs/rt operands.
- Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers. Also services MTHI and MTLO.
- o_busy drives the hazard unit, which stalls issue of further mul/div, MFHI, MFLO, MTHI and MTLO while busy.
- HI/LO outputs feed the MFHI/MFLO result mux ahead of the EX/MEM register.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/ex_muldiv_unit_seq_divider_core.sv | 46 ++++
 rtl/ex_muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared funct codes, FSM states and iteration count for the mul/div unit
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    localparam int ITER_CYCLES = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ITER   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/ex_muldiv_unit_seq_divider_core.sv
// rtl/ex_muldiv_unit_seq_divider_core.sv - restoring divider on unsigned magnitudes, one quotient bit per step
module seq_divider_core #(
    parameter int NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [NB_DATA-1:0] i_dividend,
    input  logic [NB_DATA-1:0] i_divisor,
    output logic [NB_DATA-1:0] o_quotient,
    output logic [NB_DATA-1:0] o_remainder
);

    logic [NB_DATA-1:0] r_quo;
    logic [NB_DATA-1:0] r_rem;
    logic [NB_DATA-1:0] r_div;
    logic [NB_DATA:0]   w_shift;
    logic [NB_DATA:0]   w_diff;
    logic               w_fits;

    // Partial remainder shifted left with the next dividend bit; trial subtract decides the quotient bit.
    assign w_shift = {r_rem, r_quo[NB_DATA-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_fits  = ~w_diff[NB_DATA];

    // Dividend bits shift out of r_quo as quotient bits shift in from the bottom.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (i_load) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_div <= i_divisor;
        end else if (i_step) begin
            r_rem <= w_fits ? w_diff[NB_DATA-1:0] : w_shift[NB_DATA-1:0];
            r_quo <= {r_quo[NB_DATA-2:0], w_fits};
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [NB_FUNCT-1:0] i_funct,
    input  logic [NB_DATA-1:0]  i_operand_A,
    input  logic [NB_DATA-1:0]  i_operand_B,
    input  logic                i_flush,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_div_by_zero,
    output logic [NB_DATA-1:0]  o_hi,
    output logic [NB_DATA-1:0]  o_lo
);

    localparam int NB_CNT = $clog2(ITER_CYCLES);

    state_t               r_state;
    state_t               w_state_next;
    logic [NB_CNT-1:0]    r_cnt;
    logic [2*NB_DATA-1:0] r_acc;
    logic [NB_DATA-1:0]   r_mcand;
    logic [NB_DATA-1:0]   r_hi;
    logic [NB_DATA-1:0]   r_lo;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_done;
    logic                 r_dbz;

    logic                 w_is_mul, w_is_div, w_signed, w_b_zero;
    logic                 w_a_neg, w_b_neg;
    logic [NB_DATA-1:0]   w_a_mag, w_b_mag;
    logic                 w_load, w_step, w_write, w_dbz, w_mthi, w_mtlo;
    logic [NB_DATA:0]     w_sum;
    logic [2*NB_DATA-1:0] w_acc_next;
    logic [2*NB_DATA-1:0] w_prod_fix;
    logic [NB_DATA-1:0]   w_quo, w_rem, w_quo_fix, w_rem_fix;

    assign w_is_mul = (i_funct == FUNCT_MULT) || (i_funct == FUNCT_MULTU);
    assign w_is_div = (i_funct == FUNCT_DIV)  || (i_funct == FUNCT_DIVU);
    assign w_signed = (i_funct == FUNCT_MULT) || (i_funct == FUNCT_DIV);
    assign w_b_zero = (i_operand_B == '0);
    assign w_a_neg  = w_signed & i_operand_A[NB_DATA-1];
    assign w_b_neg  = w_signed & i_operand_B[NB_DATA-1];
    assign w_a_mag  = w_a_neg ? -i_operand_A : i_operand_A;
    assign w_b_mag  = w_b_neg ? -i_operand_B : i_operand_B;

    // Shift-add step: conditionally add the multiplicand to the upper half, then shift right with carry.
    assign w_sum      = {1'b0, r_acc[2*NB_DATA-1:NB_DATA]} + {1'b0, r_mcand};
    assign w_acc_next = r_acc[0] ? {w_sum, r_acc[NB_DATA-1:1]} : {1'b0, r_acc[2*NB_DATA-1:1]};

    // Sign correction applied to the magnitude results while in FINISH.
    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -w_quo : w_quo;
    assign w_rem_fix  = r_neg_r ? -w_rem : w_rem;

    seq_divider_core #(
        .NB_DATA (NB_DATA)
    ) u_div_core (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_step      (w_step & r_is_div),
        .i_dividend  (w_a_mag),
        .i_divisor   (w_b_mag),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and per-cycle control strobes; flush overrides starting and the final write.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_write      = 1'b0;
        w_dbz        = 1'b0;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_flush) begin
                    if (w_is_mul || (w_is_div && !w_b_zero)) begin
                        w_load       = 1'b1;
                        w_state_next = ST_ITER;
                    end else if (w_is_div) begin
                        w_dbz = 1'b1;
                    end else if (i_funct == FUNCT_MTHI) begin
                        w_mthi = 1'b1;
                    end else if (i_funct == FUNCT_MTLO) begin
                        w_mtlo = 1'b1;
                    end
                end
            end
            ST_ITER: begin
                if (i_flush) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == '0) w_state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
                w_write      = !i_flush;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration counter, multiply accumulator, HI/LO and status pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= w_write;
            r_dbz  <= w_dbz;
            if (w_load) begin
                r_cnt    <= NB_CNT'(ITER_CYCLES - 1);
                r_acc    <= {{NB_DATA{1'b0}}, w_b_mag};
                r_mcand  <= w_a_mag;
                r_is_div <= w_is_div;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
            end else if (w_step) begin
                r_cnt <= r_cnt - 1'b1;
                r_acc <= w_acc_next;
            end
            if (w_write) begin
                if (r_is_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end else begin
                    r_hi <= w_prod_fix[2*NB_DATA-1:NB_DATA];
                    r_lo <= w_prod_fix[NB_DATA-1:0];
                end
            end
            if (w_mthi) r_hi <= i_operand_A;
            if (w_mtlo) r_lo <= i_operand_A;
        end
    end

    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [5:0]  funct;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    ex_muldiv_unit #(
        .NB_DATA  (32),
        .NB_FUNCT (6)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_funct       (funct),
        .i_operand_A   (opa),
        .i_operand_B   (opb),
        .i_flush       (flush),
        .o_busy        (busy),
        .o_done        (done),
        .o_div_by_zero (dbz),
        .o_hi          (hi),
        .o_lo          (lo)
    );

    always #5 clk = ~clk;

    // Drives one start cycle (cycle 0) and returns 1 time unit into cycle 1.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; funct = f; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'd0; opa = 32'd0; opb = 32'd0;
    endtask

    // Observes from cycle c0 onward; stops on the first o_done (done_cyc = -1 if none within budget).
    task automatic wait_done(input int c0, output int nbusy, output int done_cyc);
        nbusy = 0;
        done_cyc = -1;
        for (int c = c0; c <= 60; c++) begin
            if (busy) nbusy++;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct = 6'd0; opa = 32'd0; opb = 32'd0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_mult();
        int nb, dc;
        issue(F_MULT, 32'hFFFFFFFD, 32'd5);
        wait_done(1, nb, dc);
        checks++; if (nb !== 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 33", nb); end
        checks++; if (dc !== 34) begin errors++; $display("FAIL mult_done_cycle: got %0d expected 34", dc); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_multu();
        int nb, dc;
        issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(1, nb, dc);
        checks++; if (dc !== 34) begin errors++; $display("FAIL multu_done_cycle: got %0d expected 34", dc); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        issue(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(1, nb, dc);
        checks++; if (dc !== 34) begin errors++; $display("FAIL mult_m1_done_cycle: got %0d expected 34", dc); end
        checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL mult_m1_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL mult_m1_lo: got %h expected 00000001", lo); end
    endtask

    task automatic test_div();
        logic [5:0]  f_t [4] = '{F_DIV, F_DIVU, F_DIV, F_DIV};
        logic [31:0] a_t [4] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd7};
        logic [31:0] b_t [4] = '{32'd2, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE};
        logic [31:0] q_t [4] = '{32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFD};
        logic [31:0] r_t [4] = '{32'hFFFFFFFF, 32'd2, 32'h00000000, 32'h00000001};
        int nb, dc;
        for (int i = 0; i < 4; i++) begin
            issue(f_t[i], a_t[i], b_t[i]);
            wait_done(1, nb, dc);
            checks++; if (nb !== 33) begin errors++; $display("FAIL div%0d_busy_cycles: got %0d expected 33", i, nb); end
            checks++; if (lo !== q_t[i]) begin errors++; $display("FAIL div%0d_lo: got %h expected %h", i, lo, q_t[i]); end
            checks++; if (hi !== r_t[i]) begin errors++; $display("FAIL div%0d_hi: got %h expected %h", i, hi, r_t[i]); end
        end
    endtask

    task automatic test_div_by_zero();
        int busy_seen;
        issue(F_MTHI, 32'h11, 32'd0);
        issue(F_MTLO, 32'h22, 32'd0);
        checks++; if (hi !== 32'h11) begin errors++; $display("FAIL mthi_hi: got %h expected 00000011", hi); end
        checks++; if (lo !== 32'h22) begin errors++; $display("FAIL mtlo_lo: got %h expected 00000022", lo); end
        issue(F_DIVU, 32'd5, 32'd0);
        checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_pulse: got %b expected 1", dbz); end
        busy_seen = int'(busy);
        @(posedge clk); #1;
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL dbz_pulse_len: got %b expected 0", dbz); end
        for (int c = 0; c < 5; c++) begin
            if (busy) busy_seen++;
            @(posedge clk); #1;
        end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL dbz_busy: got %0d busy cycles expected 0", busy_seen); end
        checks++; if (hi !== 32'h11) begin errors++; $display("FAIL dbz_hi: got %h expected 00000011", hi); end
        checks++; if (lo !== 32'h22) begin errors++; $display("FAIL dbz_lo: got %h expected 00000022", lo); end
    endtask

    task automatic test_flush();
        int done_seen;
        issue(F_DIVU, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_at_11: got %b expected 0", busy); end
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses expected 0", done_seen); end
        checks++; if (hi !== 32'h11) begin errors++; $display("FAIL flush_hi: got %h expected 00000011", hi); end
        checks++; if (lo !== 32'h22) begin errors++; $display("FAIL flush_lo: got %h expected 00000022", lo); end
    endtask

    task automatic test_start_while_busy();
        int nb, dc;
        issue(F_MULTU, 32'd6, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; funct = F_MULT; opa = 32'd2; opb = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'd0; opa = 32'd0; opb = 32'd0;
        wait_done(6, nb, dc);
        checks++; if (dc !== 34) begin errors++; $display("FAIL swb_done_cycle: got %0d expected 34", dc); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL swb_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL swb_lo: got %h expected 0000002a", lo); end
    endtask

    task automatic test_mtlo();
        issue(F_MTLO, 32'hDEADBEEF, 32'd0);
        checks++; if (lo !== 32'hDEADBEEF) begin errors++; $display("FAIL mtlo_value: got %h expected deadbeef", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected 00000000", hi); end
    endtask

    task automatic test_reset_mid();
        int busy_seen;
        issue(F_MTHI, 32'h12345678, 32'd0);
        issue(F_MULT, 32'd3, 32'd5);
        repeat (9) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo: got %h expected 00000000", lo); end
        #1 rst = 1'b0;
        busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (busy || done) busy_seen++;
        end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL rstmid_op_lost: got %0d active cycles expected 0", busy_seen); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_by_zero();
        test_flush();
        test_start_while_busy();
        test_mtlo();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
